// File: rtl/clause_check_scheduler_pkg.sv
// Shared definitions for the clause-check datapath: scheduler FSM encoding
// and the width rules derived from the clause-index width. The memory loader
// and the proposal controller import these too.
package clause_check_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  localparam int DEF_IDX_W = 4;

  // valid pipe is vld_pipe[PIPE_STAGES:0]: [0] = enable stage, [1] = capture stage
  localparam int PIPE_STAGES = 1;

  // clause count needs one extra bit so that "all N clauses" is representable
  function automatic int clause_cnt_w(input int idx_w);
    return idx_w + 1;
  endfunction

  function automatic int clause_max(input int idx_w);
    return 1 << idx_w;
  endfunction

endpackage

// File: rtl/clause_check_scheduler_if.sv
// Request/result bundle between the scheduler, the clause memory/checker and
// the MCMC proposal logic. The scheduler sits on the slave modport.
interface clause_check_scheduler_if #(
  parameter int W = 4
);
  import clause_check_scheduler_pkg::*;

  localparam int CW = clause_cnt_w(W);
  localparam int N  = clause_max(W);

  logic          in_start;
  logic [CW-1:0] in_number_of_clauses;
  logic [W-1:0]  out_clause_address;
  logic          out_checker_enable;
  logic          in_clause_is_satisfied;
  logic          out_busy;
  logic          out_done;
  logic          out_all_satisfied;
  logic [CW-1:0] out_unsatisfied_count;
  logic [N-1:0]  out_satisfied_bitmap;
  logic          out_first_unsat_valid;
  logic [W-1:0]  out_first_unsat_index;

  // requester / checker side
  modport master (
    output in_start, in_number_of_clauses, in_clause_is_satisfied,
    input  out_clause_address, out_checker_enable, out_busy, out_done,
           out_all_satisfied, out_unsatisfied_count, out_satisfied_bitmap,
           out_first_unsat_valid, out_first_unsat_index
  );

  // scheduler side
  modport slave (
    input  in_start, in_number_of_clauses, in_clause_is_satisfied,
    output out_clause_address, out_checker_enable, out_busy, out_done,
           out_all_satisfied, out_unsatisfied_count, out_satisfied_bitmap,
           out_first_unsat_valid, out_first_unsat_index
  );

endinterface

// File: rtl/clause_check_scheduler.sv
// Clause check scheduler: walks clause addresses 0..M-1 one per cycle,
// pulses the checker enable when memory data is at the checker, and
// accumulates per-clause satisfied bits into scan results.
// Optional build macro: CLAUSE_SCHED_EARLY_EXIT_EN -- stop the scan at the
// first unsatisfied clause instead of scanning the whole formula.
module clause_check_scheduler
  import clause_check_scheduler_pkg::*;
#(
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX = DEF_IDX_W
) (
  input logic                     in_clk,
  input logic                     in_reset_n,
  clause_check_scheduler_if.slave bus
);

  localparam int W  = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int CW = clause_cnt_w(W);
  localparam int N  = clause_max(W);

  sched_state_t                   state, state_nx;
  logic [W-1:0]                   addr_q;
  logic [CW-1:0]                  m_q;
  logic [PIPE_STAGES:0]           vld_pipe;
  logic [PIPE_STAGES:0][W-1:0]    idx_pipe;

  logic                           all_sat_q;
  logic [CW-1:0]                  unsat_cnt_q;
  logic [N-1:0]                   bitmap_q;
  logic                           first_vld_q;
  logic [W-1:0]                   first_idx_q;

  logic                           start_ok;
  logic [CW-1:0]                  m_sat;
  logic                           last_issue;
  logic                           issue_now;
  logic                           capture;
  logic                           unsat_cap;
  logic                           kill;
  logic [W-1:0]                   cap_idx;

  // start decode, count saturation, issue/capture qualifiers
  always_comb begin
    start_ok   = bus.in_start && (state == ST_IDLE);
    m_sat      = (bus.in_number_of_clauses > CW'(N)) ? CW'(N) : bus.in_number_of_clauses;
    // m_q >= 1 whenever ISSUE is entered, so the subtraction never wraps here
    last_issue = (state == ST_ISSUE) && ({1'b0, addr_q} == (m_q - CW'(1)));
    capture    = vld_pipe[PIPE_STAGES];
    cap_idx    = idx_pipe[PIPE_STAGES];
    unsat_cap  = capture && !bus.in_clause_is_satisfied;
`ifdef CLAUSE_SCHED_EARLY_EXIT_EN
    kill       = unsat_cap;
`else
    kill       = 1'b0;
`endif
    issue_now  = (state == ST_ISSUE) && !kill;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start_ok) state_nx = (m_sat == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (kill) state_nx = ST_DONE;
                else if (last_issue) state_nx = ST_DRAIN;
      // leave once nothing is left behind the capture stage
      ST_DRAIN: if (kill || !vld_pipe[0]) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) state <= ST_IDLE;
    else             state <= state_nx;
  end

  // clause count latch and address counter; address holds after a scan
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      m_q    <= '0;
      addr_q <= '0;
    end else if (start_ok) begin
      m_q <= m_sat;
      if (m_sat != '0) addr_q <= '0;
    end else if (issue_now && !last_issue) begin
      addr_q <= addr_q + W'(1);
    end
  end

  // valid/index shift register: issue -> enable -> capture
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe <= kill ? '0 : {vld_pipe[PIPE_STAGES-1:0], issue_now};
      idx_pipe <= {idx_pipe[PIPE_STAGES-1:0], addr_q};
    end
  end

  // result accumulator; cleared on accepted start, then frozen until the next one
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      all_sat_q   <= 1'b1;
      unsat_cnt_q <= '0;
      bitmap_q    <= '0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else if (start_ok) begin
      all_sat_q   <= 1'b1;
      unsat_cnt_q <= '0;
      bitmap_q    <= '0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else if (capture) begin
      if (!unsat_cap) begin
        bitmap_q[cap_idx] <= 1'b1;
      end else begin
        bitmap_q[cap_idx] <= 1'b0;
        unsat_cnt_q       <= unsat_cnt_q + CW'(1);
        all_sat_q         <= 1'b0;
        if (!first_vld_q) begin
          first_vld_q <= 1'b1;
          first_idx_q <= cap_idx;
        end
      end
    end
  end

  assign bus.out_clause_address    = addr_q;
  assign bus.out_checker_enable    = vld_pipe[0];
  assign bus.out_busy              = (state != ST_IDLE);
  assign bus.out_done              = (state == ST_DONE);
  assign bus.out_all_satisfied     = all_sat_q;
  assign bus.out_unsatisfied_count = unsat_cnt_q;
  assign bus.out_satisfied_bitmap  = bitmap_q;
  assign bus.out_first_unsat_valid = first_vld_q;
  assign bus.out_first_unsat_index = first_idx_q;

endmodule

// File: tb/tb_clause_check_scheduler.sv
// Bench for clause_check_scheduler: clause memory + checker model drives the
// satisfied bit from a per-clause table; a scan-level model predicts latency,
// results and the issued address sequence.
module tb_clause_check_scheduler;
  import clause_check_scheduler_pkg::*;

  localparam int W  = 4;
  localparam int N  = 16;
  localparam int CW = 5;

  logic in_clk = 1'b0;
  logic in_reset_n;
  always #5 in_clk = ~in_clk;

  clause_check_scheduler_if #(.W(W)) bus ();

  clause_check_scheduler #(.MAX_BIT_WIDTH_OF_CLAUSES_INDEX(W)) dut (
    .in_clk     (in_clk),
    .in_reset_n (in_reset_n),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [N-1:0] sat_tbl;
  logic [W-1:0] mem_q;
  int           issued[$];

  // memory (1-cycle read) feeding the checker; result one cycle after enable
  always @(posedge in_clk) begin
    mem_q <= bus.out_clause_address;
    if (bus.out_checker_enable) begin
      bus.in_clause_is_satisfied <= sat_tbl[mem_q];
      issued.push_back(int'(mem_q));
    end else begin
      bus.in_clause_is_satisfied <= 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int           lat;
    bit           all;
    int           cnt;
    logic [N-1:0] bmp;
    bit           fv;
    int           fi;
    int           nen;   // expected enables, -1 = not predicted
  } exp_t;

  function automatic exp_t model(input int m, input logic [N-1:0] tbl);
    exp_t e;
    int   ms;
    ms    = (m > N) ? N : m;
    e.all = 1; e.cnt = 0; e.bmp = '0; e.fv = 0; e.fi = 0; e.nen = ms;
    e.lat = (ms == 0) ? 1 : ms + 3;
    for (int i = 0; i < ms; i++) begin
      if (tbl[i]) e.bmp[i] = 1'b1;
      else begin
        e.cnt++; e.all = 0;
        if (!e.fv) begin e.fv = 1; e.fi = i; end
      end
    end
`ifdef CLAUSE_SCHED_EARLY_EXIT_EN
    if (e.fv) begin
      e.cnt = 1;
      e.bmp = N'((1 << e.fi) - 1);
      e.lat = e.fi + 4;
      e.nen = -1;
    end
`endif
    return e;
  endfunction

  task automatic chk_results(input string tag, input exp_t e);
    chk({tag, "_all"},  bus.out_all_satisfied,     e.all);
    chk({tag, "_cnt"},  bus.out_unsatisfied_count, e.cnt);
    chk({tag, "_bmp"},  bus.out_satisfied_bitmap,  e.bmp);
    chk({tag, "_fv"},   bus.out_first_unsat_valid, e.fv);
    chk({tag, "_fi"},   bus.out_first_unsat_index, e.fi);
  endtask

  // one scan; 'extra' adds a start while busy and a start coincident with done
  task automatic run_scan(input string tag, input int m, input bit extra);
    exp_t        e;
    int          cyc;
    int          nbad;
    logic [W-1:0] addr0;
    e = model(m, sat_tbl);
    @(negedge in_clk);
    issued.delete();
    addr0 = bus.out_clause_address;
    bus.in_start = 1'b1;
    bus.in_number_of_clauses = CW'(m);
    @(negedge in_clk);
    bus.in_start = 1'b0;
    cyc = 1;
    // nothing can be captured yet: results must read as freshly cleared
    chk({tag, "_clr_all"}, bus.out_all_satisfied, 1);
    chk({tag, "_clr_cnt"}, bus.out_unsatisfied_count, 0);
    chk({tag, "_clr_bmp"}, bus.out_satisfied_bitmap, 0);
    chk({tag, "_busy"},    bus.out_busy, 1);
    while (!bus.out_done && cyc < 100) begin
      bus.in_start = extra && (cyc == 2);
      if (extra && cyc == 2) bus.in_number_of_clauses = CW'(3);
      @(negedge in_clk);
      cyc++;
    end
    bus.in_start = 1'b0;
    chk({tag, "_lat"}, cyc, e.lat);
    chk_results(tag, e);
    if (e.nen >= 0) begin
      nbad = (issued.size() == e.nen) ? 0 : 1;
      foreach (issued[i]) if (issued[i] != i) nbad++;
      chk({tag, "_addr_seq"}, nbad, 0);
    end
    if (m == 0) chk({tag, "_addr_hold"}, bus.out_clause_address, addr0);
    if (extra) begin
      bus.in_start = 1'b1;
      bus.in_number_of_clauses = CW'(7);
    end
    @(negedge in_clk);
    bus.in_start = 1'b0;
    @(negedge in_clk);
    chk({tag, "_idle"}, {bus.out_busy, bus.out_done, bus.out_checker_enable}, 3'b000);
    chk_results({tag, "_hold"}, e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, bus.out_busy, 0);
    chk({tag, "_done"}, bus.out_done, 0);
    chk({tag, "_en"},   bus.out_checker_enable, 0);
    chk({tag, "_addr"}, bus.out_clause_address, 0);
    chk({tag, "_all"},  bus.out_all_satisfied, 1);
    chk({tag, "_cnt"},  bus.out_unsatisfied_count, 0);
    chk({tag, "_bmp"},  bus.out_satisfied_bitmap, 0);
    chk({tag, "_fv"},   bus.out_first_unsat_valid, 0);
    chk({tag, "_fi"},   bus.out_first_unsat_index, 0);
  endtask

  initial begin
    int k;
    in_reset_n = 1'b0;
    bus.in_start = 1'b0;
    bus.in_number_of_clauses = '0;
    sat_tbl = '1;
    repeat (3) @(negedge in_clk);
    chk_reset_vals("rst");
    in_reset_n = 1'b1;

    sat_tbl = 16'hFFFF;              run_scan("t1_allsat", 5, 0);
    sat_tbl = 16'hFFF5;              run_scan("t2_mixed", 5, 0);
    run_scan("t3_zero", 0, 0);
    sat_tbl = 16'h5AF7;              run_scan("t4_sat20", 20, 0);
    sat_tbl = 16'h00EE;              run_scan("t5_dup", 5, 1);
    sat_tbl = 16'hFFFB;              run_scan("t7_fail2", 8, 0);

    // reset in the middle of a scan, then a clean rescan
    sat_tbl = 16'h0F0F;
    @(negedge in_clk);
    bus.in_start = 1'b1;
    bus.in_number_of_clauses = CW'(8);
    @(negedge in_clk);
    bus.in_start = 1'b0;
    k = 0;
    while (!(bus.out_busy && bus.out_clause_address == 3) && k < 50) begin
      @(negedge in_clk);
      k++;
    end
    chk("t6_reach3", k < 50, 1);
    in_reset_n = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    @(negedge in_clk);
    in_reset_n = 1'b1;
    run_scan("t6_clean", 8, 0);

    for (int i = 0; i < 25; i++) begin
      sat_tbl = (i % 3 == 0) ? 16'hFFFF : N'($urandom) | N'($urandom);
      run_scan($sformatf("rnd%0d", i), int'($urandom_range(0, 20)), (i % 5) == 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
